round_key_store: RTL and testbench

//  Consumer end of the key-expansion write interface: captures round keys written by round_key
//  (w_e/round_key_addr/round_key), then streams them to the cipher datapath one per round.

---
 rtl/round_key_store_pkg.sv | 19 +
 rtl/round_key_store_ram.sv | 39 +++
 rtl/round_key_store.sv | 158 +++++++++++++++
 tb/tb_round_key_store.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/round_key_store_pkg.sv
// Shared constants and FSM encoding for the round-key store.
package round_key_store_pkg;

  localparam int NB      = 4;
  localparam int NR_128  = 10;
  localparam int NR_256  = 14;
  localparam int RK_BITS = 128;

  // Round index width matches Nb; storage holds the longest (AES-256) schedule.
  localparam int RK_ADDR_W = NB;
  localparam int RK_DEPTH  = NR_256 + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/round_key_store_ram.sv
// Round-key storage: one write port, one registered read port.
// The write array has no reset so it maps onto block or distributed RAM;
// only the read register is reset so key_out reads 0 after reset.
module round_key_store_ram
  import round_key_store_pkg::*;
#(
  parameter int WIDTH  = RK_BITS,
  parameter int DEPTH  = RK_DEPTH,
  parameter int ADDR_W = RK_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; the caller guarantees waddr is in range when we is high.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value while re is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/round_key_store.sv
// Captures round keys from the key-expansion write interface and streams
// them to the cipher datapath, forward (0..nr) or reverse (nr..0).
//
// Output handshake: key_out/round_idx/key_last are meaningful while
// key_valid is 1 and stay stable until the consumer asserts next; a key is
// consumed on every clock edge where key_valid && next are both 1, so next
// held high yields one key per clock.
module round_key_store
  import round_key_store_pkg::*;
#(
  parameter int ROUND_KEY_BITS = RK_BITS,
  parameter int ADDR_W         = RK_ADDR_W,
  parameter int DEPTH          = RK_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      w_e,
  input  logic [ADDR_W-1:0]         w_addr,
  input  logic [ROUND_KEY_BITS-1:0] w_key,
  input  logic                      exp_done,
  input  logic [ADDR_W-1:0]         rounds_total,
  input  logic                      start,
  input  logic                      decrypt,
  input  logic                      next,
  output logic [ROUND_KEY_BITS-1:0] key_out,
  output logic                      key_valid,
  output logic                      key_last,
  output logic [ADDR_W-1:0]         round_idx,
  output logic                      busy,
  output logic                      keys_ready,
  output logic                      err,
  output state_t                    fsm_state
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] nr;
  logic              dir_rev;

  logic [ADDR_W-1:0] end_idx;
  logic [ADDR_W-1:0] ptr_next;
  logic              wr_ok;
  logic              cfg_ok;
  logic              abort;
  logic              advance;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;

  // Stream bookkeeping: where it stops, the next index, and what moves it.
  always_comb begin
    end_idx  = dir_rev ? '0 : nr;
    ptr_next = dir_rev ? ptr - 1'b1 : ptr + 1'b1;
    wr_ok    = w_e && (w_addr <= LAST_IDX);
    cfg_ok   = rounds_total <= LAST_IDX;
    abort    = busy && (w_e || exp_done);
    advance  = (state == STREAM) && next && !key_last;
    rd_en    = !abort && ((state == LOAD) || advance);
    rd_addr  = (state == LOAD) ? ptr : ptr_next;
  end

  assign fsm_state = state;

  round_key_store_ram #(
    .WIDTH  (ROUND_KEY_BITS),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_ok),
    .waddr (w_addr),
    .wdata (w_key),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (key_out)
  );

  // Schedule-ready tracking, error pulse and the IDLE/LOAD/STREAM sequencer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      nr         <= '0;
      dir_rev    <= 1'b0;
      round_idx  <= '0;
      key_valid  <= 1'b0;
      key_last   <= 1'b0;
      busy       <= 1'b0;
      keys_ready <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;

      // A completed expansion wins over a write in the same cycle.
      if (exp_done) begin
        if (cfg_ok) begin
          nr         <= rounds_total;
          keys_ready <= 1'b1;
        end else begin
          keys_ready <= 1'b0;
          err        <= 1'b1;
        end
      end else if (w_e) begin
        keys_ready <= 1'b0;
      end

      if (abort) begin
        // The schedule changed underneath a running stream.
        state     <= IDLE;
        key_valid <= 1'b0;
        key_last  <= 1'b0;
        busy      <= 1'b0;
        err       <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (keys_ready) begin
                ptr     <= decrypt ? nr : '0;
                dir_rev <= decrypt;
                busy    <= 1'b1;
                state   <= LOAD;
              end else begin
                err <= 1'b1;
              end
            end
          end
          LOAD: begin
            round_idx <= ptr;
            key_valid <= 1'b1;
            key_last  <= (ptr == end_idx);
            state     <= STREAM;
          end
          STREAM: begin
            if (next) begin
              if (key_last) begin
                key_valid <= 1'b0;
                key_last  <= 1'b0;
                busy      <= 1'b0;
                state     <= IDLE;
              end else begin
                ptr       <= ptr_next;
                round_idx <= ptr_next;
                key_last  <= (ptr_next == end_idx);
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_round_key_store.sv
// Directed-plus-random bench for round_key_store with an array model of the
// key store and an expected-key queue per stream.
module tb_round_key_store;
  import round_key_store_pkg::*;

  localparam int W  = RK_BITS;
  localparam int AW = RK_ADDR_W;
  localparam int D  = RK_DEPTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          w_e;
  logic [AW-1:0] w_addr;
  logic [W-1:0]  w_key;
  logic          exp_done;
  logic [AW-1:0] rounds_total;
  logic          start;
  logic          decrypt;
  logic          next;
  logic [W-1:0]  key_out;
  logic          key_valid;
  logic          key_last;
  logic [AW-1:0] round_idx;
  logic          busy;
  logic          keys_ready;
  logic          err;
  state_t        fsm_state;

  round_key_store dut (
    .clk          (clk),
    .reset        (reset),
    .w_e          (w_e),
    .w_addr       (w_addr),
    .w_key        (w_key),
    .exp_done     (exp_done),
    .rounds_total (rounds_total),
    .start        (start),
    .decrypt      (decrypt),
    .next         (next),
    .key_out      (key_out),
    .key_valid    (key_valid),
    .key_last     (key_last),
    .round_idx    (round_idx),
    .busy         (busy),
    .keys_ready   (keys_ready),
    .err          (err),
    .fsm_state    (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference model: what the store should hold and whether it is armed.
  logic [W-1:0] model_mem [D];
  int           model_nr;
  bit           model_ready;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int           idx_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Driver: one write cycle, no stream running.
  task automatic write_key(input int a, input logic [W-1:0] k);
    w_e    = 1'b1;
    w_addr = AW'(a);
    w_key  = k;
    tick();
    w_e = 1'b0;
    if (a < D) model_mem[a] = k;
    model_ready = 1'b0;
    check("wr_ready_clear", keys_ready, 0);
    check("wr_no_err", err, 0);
  endtask

  // Driver: expansion-complete pulse.
  task automatic finish_exp(input int n);
    bit bad;
    exp_done     = 1'b1;
    rounds_total = AW'(n);
    tick();
    exp_done = 1'b0;
    bad = (n > D - 1);
    if (!bad) begin
      model_nr    = n;
      model_ready = 1'b1;
    end else begin
      model_ready = 1'b0;
    end
    check("exp_ready", keys_ready, model_ready);
    check("exp_err", err, bad);
    if (bad) begin
      tick();
      check("exp_err_one_clk", err, 0);
    end
  endtask

  // Driver + scoreboard for a complete stream; stall selects the 1,0,0,1 next pattern.
  task automatic run_stream(input logic dec, input bit stall);
    int pat [4] = '{1, 0, 0, 1};
    int step;
    int budget;
    int nxt;
    exp_q.delete();
    idx_q.delete();
    for (int i = 0; i <= model_nr; i++) begin
      int j;
      j = dec ? model_nr - i : i;
      exp_q.push_back(model_mem[j]);
      idx_q.push_back(j);
    end
    start   = 1'b1;
    decrypt = dec;
    next    = !stall;
    tick();
    start = 1'b0;
    check("load_busy", busy, 1);
    check("load_valid", key_valid, 0);
    check("load_err", err, 0);
    tick();
    step   = 0;
    budget = 200;
    while (exp_q.size() > 0 && budget > 0) begin
      nxt = stall ? pat[step % 4] : 1;
      check("st_valid", key_valid, 1);
      check("st_key", key_out, exp_q[0]);
      check("st_idx", round_idx, W'(idx_q[0]));
      check("st_last", key_last, exp_q.size() == 1);
      // A start while streaming must be ignored without error.
      if (step == 1) begin
        start   = 1'b1;
        decrypt = ~dec;
      end
      next = nxt[0];
      tick();
      start = 1'b0;
      check("st_err", err, 0);
      if (nxt != 0) begin
        void'(exp_q.pop_front());
        void'(idx_q.pop_front());
      end
      step++;
      budget--;
    end
    next = 1'b0;
    check("stream_drained", W'(exp_q.size()), 0);
    check("end_busy", busy, 0);
    check("end_valid", key_valid, 0);
    check("end_last", key_last, 0);
  endtask

  initial begin
    logic [W-1:0] k;

    reset = 1'b0;
    w_e = 1'b0; w_addr = '0; w_key = '0;
    exp_done = 1'b0; rounds_total = '0;
    start = 1'b0; decrypt = 1'b0; next = 1'b0;
    model_nr = 0;
    model_ready = 1'b0;
    for (int i = 0; i < D; i++) model_mem[i] = '0;

    #22;
    check("rst_key", key_out, 0);
    check("rst_valid", key_valid, 0);
    check("rst_last", key_last, 0);
    check("rst_idx", round_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", keys_ready, 0);
    check("rst_err", err, 0);
    reset = 1'b1;
    tick();

    // start before any schedule exists
    start = 1'b1;
    tick();
    start = 1'b0;
    check("early_start_err", err, 1);
    check("early_start_valid", key_valid, 0);
    check("early_start_busy", busy, 0);
    tick();
    check("early_start_err_one_clk", err, 0);

    // out-of-range round count
    finish_exp(15);

    // AES-128 schedule
    for (int i = 0; i <= NR_128; i++) write_key(i, rand_key());
    write_key(0, 128'h0f0e0d0c0b0a09080706050403020100);
    write_key(10, 128'hc5302b4d8ba707f3174a94e37f1d1113);
    write_key(15, rand_key());
    finish_exp(NR_128);
    run_stream(1'b0, 1'b0);
    run_stream(1'b1, 1'b0);
    run_stream(1'b0, 1'b1);
    run_stream(1'b1, 1'b1);

    // AES-256 schedule
    for (int i = 0; i <= NR_256; i++) write_key(i, rand_key());
    write_key(0, 128'h0f0e0d0c0b0a09080706050403020100);
    write_key(1, 128'h1f1e1d1c1b1a19181716151413121110);
    write_key(14, 128'h36de686d3cc21a37e97909bfcc79fc24);
    finish_exp(NR_256);
    run_stream(1'b0, 1'b0);
    run_stream(1'b1, 1'b1);

    // write and expansion-complete in the same cycle
    k = rand_key();
    w_e = 1'b1; w_addr = 4'd7; w_key = k;
    exp_done = 1'b1; rounds_total = 4'd12;
    tick();
    w_e = 1'b0; exp_done = 1'b0;
    model_mem[7] = k;
    model_nr = 12;
    model_ready = 1'b1;
    check("same_cycle_ready", keys_ready, 1);
    check("same_cycle_err", err, 0);
    run_stream(1'b1, 1'b0);

    // write aborts a running stream
    start = 1'b1; decrypt = 1'b0; next = 1'b0;
    tick();
    start = 1'b0;
    tick();
    check("ab_key0", key_out, model_mem[0]);
    next = 1'b1;
    tick();
    next = 1'b0;
    check("ab_key1", key_out, model_mem[1]);
    check("ab_idx1", round_idx, 1);
    k = rand_key();
    w_e = 1'b1; w_addr = 4'd3; w_key = k;
    tick();
    w_e = 1'b0;
    model_mem[3] = k;
    model_ready = 1'b0;
    check("ab_err", err, 1);
    check("ab_busy", busy, 0);
    check("ab_valid", key_valid, 0);
    check("ab_last", key_last, 0);
    check("ab_ready", keys_ready, 0);
    tick();
    check("ab_err_one_clk", err, 0);
    finish_exp(12);
    run_stream(1'b0, 1'b1);

    // expansion-complete aborts a running stream and re-arms
    start = 1'b1; decrypt = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("ab2_key", key_out, model_mem[12]);
    exp_done = 1'b1; rounds_total = 4'd10;
    tick();
    exp_done = 1'b0;
    model_nr = 10;
    check("ab2_err", err, 1);
    check("ab2_busy", busy, 0);
    check("ab2_valid", key_valid, 0);
    check("ab2_ready", keys_ready, 1);
    tick();
    check("ab2_err_one_clk", err, 0);
    run_stream(1'b1, 1'b0);

    // asynchronous reset mid-stream
    start = 1'b1; decrypt = 1'b0;
    tick();
    start = 1'b0;
    tick();
    next = 1'b1;
    tick();
    next = 1'b0;
    check("pre_rst_valid", key_valid, 1);
    #1;
    reset = 1'b0;
    #1;
    model_ready = 1'b0;
    model_nr = 0;
    check("arst_key", key_out, 0);
    check("arst_valid", key_valid, 0);
    check("arst_last", key_last, 0);
    check("arst_idx", round_idx, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", keys_ready, 0);
    check("arst_err", err, 0);
    tick();
    reset = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("post_rst_start_err", err, 1);
    check("post_rst_start_valid", key_valid, 0);
    tick();
    check("post_rst_err_one_clk", err, 0);

    // storage survives reset
    finish_exp(NR_128);
    run_stream(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
